// File: rtl/rggen_apb_bridge_if.sv
// rggen_apb_bridge_if: register-bus and APB interfaces of the APB bridge
interface rggen_apb_bridge_bus_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic request;
  logic [ADDRESS_WIDTH-1:0] address;
  logic write;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_WIDTH/8-1:0] strobe;
  logic done;
  logic [DATA_WIDTH-1:0] read_data;
  logic [1:0] status;
  modport master(output request, address, write, write_data, strobe, input done, read_data, status);
  modport slave(input request, address, write, write_data, strobe, output done, read_data, status);
endinterface

interface rggen_apb_bridge_apb_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic psel;
  logic penable;
  logic pwrite;
  logic [ADDRESS_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [2:0] pprot;
  logic pready;
  logic [DATA_WIDTH-1:0] prdata;
  logic pslverr;
  modport master(output psel, penable, pwrite, paddr, pwdata, pstrb, pprot, input pready, prdata, pslverr);
  modport slave(input psel, penable, pwrite, paddr, pwdata, pstrb, pprot, output pready, prdata, pslverr);
endinterface

// File: rtl/rggen_apb_bridge.sv
// rggen_apb_bridge: register-bus to APB3/APB4 master bridge with optional ACCESS-phase timeout
module rggen_apb_bridge #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic clk,
  input logic rst_n,
  rggen_apb_bridge_bus_if.slave bus,
  rggen_apb_bridge_apb_if.master apb
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int CW = TIMEOUT_CYCLES == 0 ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TIMEOUT = CW'(TIMEOUT_CYCLES);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK = ~ADDRESS_WIDTH'(SW - 1);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] count, count_n, count_inc;
  logic psel_n, penable_n, pwrite_n, done_n, timeout;
  logic [ADDRESS_WIDTH-1:0] paddr_n;
  logic [DATA_WIDTH-1:0] pwdata_n, read_data_n;
  logic [SW-1:0] pstrb_n;
  logic [1:0] status_n;
  assign count_inc = count + CW'(1);
  assign timeout = TIMEOUT_CYCLES != 0 && count_inc == TIMEOUT;
  assign apb.pprot = 3'b000;
  always_comb begin
    state_n = state;
    count_n = count;
    psel_n = apb.psel;
    penable_n = apb.penable;
    pwrite_n = apb.pwrite;
    paddr_n = apb.paddr;
    pwdata_n = apb.pwdata;
    pstrb_n = apb.pstrb;
    done_n = 1'b0;
    read_data_n = bus.read_data;
    status_n = bus.status;
    case (state)
      IDLE: if (bus.request) begin
        state_n = SETUP;
        count_n = '0;
        psel_n = 1'b1;
        penable_n = 1'b0;
        pwrite_n = bus.write;
        paddr_n = bus.address & ADDR_MASK;
        pwdata_n = bus.write ? bus.write_data : '0;
        pstrb_n = bus.write ? bus.strobe : '0;
      end
      SETUP: begin
        state_n = ACCESS;
        penable_n = 1'b1;
      end
      // a timeout drops psel without pready, deliberately breaking the APB hold rule
      ACCESS: if (apb.pready || timeout) begin
        state_n = DONE;
        psel_n = 1'b0;
        penable_n = 1'b0;
        done_n = 1'b1;
        read_data_n = (apb.pready && !apb.pwrite) ? apb.prdata : '0;
        status_n = apb.pready ? {apb.pslverr, 1'b0} : 2'b11;
      end else begin
        count_n = count_inc;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      apb.psel <= 1'b0;
      apb.penable <= 1'b0;
      apb.pwrite <= 1'b0;
      apb.paddr <= '0;
      apb.pwdata <= '0;
      apb.pstrb <= '0;
      bus.done <= 1'b0;
      bus.read_data <= '0;
      bus.status <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
      apb.psel <= psel_n;
      apb.penable <= penable_n;
      apb.pwrite <= pwrite_n;
      apb.paddr <= paddr_n;
      apb.pwdata <= pwdata_n;
      apb.pstrb <= pstrb_n;
      bus.done <= done_n;
      bus.read_data <= read_data_n;
      bus.status <= status_n;
    end
  end
endmodule
